// File: rtl/edge_video_output_stage.sv
// Output stage of the edge-detection video path: realigns syncs/pixels with the late Sobel
// result, composes the display-mode pixel and flags bad line lengths. EDGE_OUT_TP_EN adds mode-3 colour bars.
module edge_video_output_stage #(
  parameter int PIX_W   = 8,
  parameter int CH      = 3,
  parameter int LATENCY = 4,
  parameter int H_ACT   = 640
) (
  input  logic                I_PCLK,
  input  logic                I_RST,
  input  logic [CH*PIX_W-1:0] I_PIX_DATA,
  input  logic                I_VSYNC,
  input  logic                I_HSYNC,
  input  logic                I_DE,
  input  logic [PIX_W-1:0]    I_EDGE,
  input  logic [1:0]          I_MODE,
  input  logic [PIX_W-1:0]    I_THRESH,
  input  logic [CH*PIX_W-1:0] I_OVL_COLOR,
  output logic [CH*PIX_W-1:0] O_PIX_DATA,
  output logic                O_VSYNC,
  output logic                O_HSYNC,
  output logic                O_DE,
  output logic [15:0]         O_FRAME_CNT,
  output logic                O_LINE_ERR
);
  localparam int DW    = CH * PIX_W;
  localparam int DEPTH = LATENCY + 1;
  localparam int COL_W = $clog2(H_ACT + 1);
  localparam logic [COL_W-1:0] COL_MAX  = '1;
  localparam logic [COL_W-1:0] COL_LINE = COL_W'(H_ACT);

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_OVL  = 2'd2,
    MODE_TP   = 2'd3
  } mode_e;

  logic [DW-1:0]    pix_sr_q [DEPTH];
  logic [DW-1:0]    pix_sr_d [DEPTH];
  logic [DEPTH-1:0] vs_sr_q, vs_sr_d, hs_sr_q, hs_sr_d, de_sr_q, de_sr_d;
  logic [PIX_W-1:0] edge_q, edge_d, thr_q, thr_d;
  mode_e            mode_q, mode_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             line_err_q, line_err_d;
  logic [DW-1:0]    pix_out_q, pix_out_d;
  logic             vs_out_q, vs_out_d, hs_out_q, hs_out_d, de_out_q, de_out_d;
  logic [DW-1:0]    pix_al, pix_comp;
  logic             vs_al, de_al, frame_evt, de_fall;

  // Input register plus LATENCY further stages, so the tap lines up with the registered I_EDGE.
  always_comb begin
    pix_sr_d[0] = I_PIX_DATA;
    for (int i = 1; i < DEPTH; i++) pix_sr_d[i] = pix_sr_q[i-1];
    vs_sr_d = {vs_sr_q[DEPTH-2:0], I_VSYNC};
    hs_sr_d = {hs_sr_q[DEPTH-2:0], I_HSYNC};
    de_sr_d = {de_sr_q[DEPTH-2:0], I_DE};
    edge_d  = I_EDGE;
  end

  assign pix_al = pix_sr_q[DEPTH-1];
  assign vs_al  = vs_sr_q[DEPTH-1];
  assign de_al  = de_sr_q[DEPTH-1];

`ifdef EDGE_OUT_TP_EN
  localparam int BAR_W = (H_ACT >= 8) ? H_ACT / 8 : 1;
  logic [31:0]   bar_n;
  logic [2:0]    bar_idx;
  logic [DW-1:0] tp_pix;

  // Bar index bits map straight to channel enables: bit0 off = blue, bit2 off = green, bit1 off = red.
  always_comb begin
    bar_n   = 32'(col_q) / 32'(BAR_W);
    bar_idx = (bar_n > 32'd7) ? 3'd7 : bar_n[2:0];
    tp_pix  = '0;
    for (int c = 0; c < CH; c++) begin
      if (c == 0)      tp_pix[c*PIX_W +: PIX_W] = {PIX_W{~bar_idx[0]}};
      else if (c == 1) tp_pix[c*PIX_W +: PIX_W] = {PIX_W{~bar_idx[2]}};
      else if (c == 2) tp_pix[c*PIX_W +: PIX_W] = {PIX_W{~bar_idx[1]}};
    end
  end
`endif

  always_comb begin
    pix_comp = pix_al;
    case (mode_q)
      MODE_GRAY: for (int c = 0; c < CH; c++) pix_comp[c*PIX_W +: PIX_W] = edge_q;
      MODE_OVL:  if (edge_q >= thr_q) pix_comp = I_OVL_COLOR;
`ifdef EDGE_OUT_TP_EN
      MODE_TP:   pix_comp = tp_pix;
`else
      MODE_TP:   pix_comp = pix_al;
`endif
      default:   pix_comp = pix_al;
    endcase
  end

  // The output sync registers double as the one-cycle-delayed copies used for edge detection.
  always_comb begin
    frame_evt   = vs_al & ~vs_out_q;
    de_fall     = de_out_q & ~de_al;
    mode_d      = mode_q;
    thr_d       = thr_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_evt) begin
      mode_d      = mode_e'(I_MODE);
      thr_d       = I_THRESH;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    col_d = col_q;
    if (de_fall) col_d = '0;
    else if (de_al && (col_q != COL_MAX)) col_d = col_q + COL_W'(1);
    line_err_d = line_err_q | (de_fall & (col_q != COL_LINE));
    pix_out_d  = de_al ? pix_comp : '0;
    vs_out_d   = vs_al;
    hs_out_d   = hs_sr_q[DEPTH-1];
    de_out_d   = de_al;
  end

  always_ff @(posedge I_PCLK) begin
    if (I_RST) begin
      for (int i = 0; i < DEPTH; i++) pix_sr_q[i] <= '0;
      vs_sr_q     <= '0;
      hs_sr_q     <= '0;
      de_sr_q     <= '0;
      edge_q      <= '0;
      thr_q       <= '0;
      mode_q      <= MODE_PASS;
      col_q       <= '0;
      frame_cnt_q <= '0;
      line_err_q  <= 1'b0;
      pix_out_q   <= '0;
      vs_out_q    <= 1'b0;
      hs_out_q    <= 1'b0;
      de_out_q    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) pix_sr_q[i] <= pix_sr_d[i];
      vs_sr_q     <= vs_sr_d;
      hs_sr_q     <= hs_sr_d;
      de_sr_q     <= de_sr_d;
      edge_q      <= edge_d;
      thr_q       <= thr_d;
      mode_q      <= mode_d;
      col_q       <= col_d;
      frame_cnt_q <= frame_cnt_d;
      line_err_q  <= line_err_d;
      pix_out_q   <= pix_out_d;
      vs_out_q    <= vs_out_d;
      hs_out_q    <= hs_out_d;
      de_out_q    <= de_out_d;
    end
  end

  assign O_PIX_DATA  = pix_out_q;
  assign O_VSYNC     = vs_out_q;
  assign O_HSYNC     = hs_out_q;
  assign O_DE        = de_out_q;
  assign O_FRAME_CNT = frame_cnt_q;
  assign O_LINE_ERR  = line_err_q;

endmodule

// File: tb/tb_edge_video_output_stage.sv
// Directed bench for edge_video_output_stage: alignment latency, display modes, frame counting,
// sticky line-length flag, mid-line reset and (with EDGE_OUT_TP_EN) the colour bars.
module tb_edge_video_output_stage;
  localparam int PIX_W   = 8;
  localparam int CH      = 3;
  localparam int LATENCY = 4;
  localparam int H_ACT   = 640;
  localparam int LOG_N   = 16384;

  logic                I_PCLK;
  logic                I_RST;
  logic [CH*PIX_W-1:0] I_PIX_DATA;
  logic                I_VSYNC, I_HSYNC, I_DE;
  logic [PIX_W-1:0]    I_EDGE;
  logic [1:0]          I_MODE;
  logic [PIX_W-1:0]    I_THRESH;
  logic [CH*PIX_W-1:0] I_OVL_COLOR;
  logic [CH*PIX_W-1:0] O_PIX_DATA;
  logic                O_VSYNC, O_HSYNC, O_DE;
  logic [15:0]         O_FRAME_CNT;
  logic                O_LINE_ERR;

  edge_video_output_stage #(
    .PIX_W(PIX_W), .CH(CH), .LATENCY(LATENCY), .H_ACT(H_ACT)
  ) dut (
    .I_PCLK(I_PCLK), .I_RST(I_RST), .I_PIX_DATA(I_PIX_DATA),
    .I_VSYNC(I_VSYNC), .I_HSYNC(I_HSYNC), .I_DE(I_DE), .I_EDGE(I_EDGE),
    .I_MODE(I_MODE), .I_THRESH(I_THRESH), .I_OVL_COLOR(I_OVL_COLOR),
    .O_PIX_DATA(O_PIX_DATA), .O_VSYNC(O_VSYNC), .O_HSYNC(O_HSYNC), .O_DE(O_DE),
    .O_FRAME_CNT(O_FRAME_CNT), .O_LINE_ERR(O_LINE_ERR)
  );

  initial I_PCLK = 1'b0;
  always #5 I_PCLK = ~I_PCLK;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Sobel stand-in: the edge value pushed with a pixel reappears on I_EDGE LATENCY edges later.
  logic [PIX_W-1:0] ehist [LATENCY];

  logic [31:0] log_pix [LOG_N];
  logic [31:0] log_vs  [LOG_N];
  logic [31:0] log_hs  [LOG_N];
  logic [31:0] log_de  [LOG_N];
  logic [31:0] log_err [LOG_N];
  logic [31:0] log_fc  [LOG_N];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One pixel clock: drive inputs, take the edge, log the outputs seen just after it.
  task automatic applyStimulus(input logic rst, input logic [23:0] pix, input logic vs,
                               input logic hs, input logic de, input logic [7:0] edgev);
    I_RST      = rst;
    I_PIX_DATA = pix;
    I_VSYNC    = vs;
    I_HSYNC    = hs;
    I_DE       = de;
    I_EDGE     = ehist[LATENCY-1];
    @(posedge I_PCLK);
    #1;
    for (int i = LATENCY - 1; i > 0; i--) ehist[i] = ehist[i-1];
    ehist[0] = edgev;
    if (cyc < LOG_N) begin
      log_pix[cyc] = 32'(O_PIX_DATA);
      log_vs[cyc]  = 32'(O_VSYNC);
      log_hs[cyc]  = 32'(O_HSYNC);
      log_de[cyc]  = 32'(O_DE);
      log_err[cyc] = 32'(O_LINE_ERR);
      log_fc[cyc]  = 32'(O_FRAME_CNT);
    end
    cyc++;
  endtask

  function automatic logic [7:0] edgeFor(input int kind, input int i);
    logic [7:0] tbl [4];
    tbl = '{8'h7F, 8'h80, 8'hFF, 8'h00};
    case (kind)
      1:       return (i == 0) ? 8'h5A : 8'(i);
      2:       return (i < 4) ? tbl[i] : 8'h10;
      default: return 8'h00;
    endcase
  endfunction

  // Active line of npix pixels followed by 10 blank cycles with an hsync pulse at blank cycle 2.
  task automatic runLine(input int npix, input logic [23:0] first_pix, input logic [23:0] pix,
                         input int kind, input int chg_at, input logic [1:0] chg_mode,
                         input logic [7:0] chg_thr, output int start);
    start = cyc;
    for (int i = 0; i < npix; i++) begin
      if (i == chg_at) begin
        I_MODE   = chg_mode;
        I_THRESH = chg_thr;
      end
      applyStimulus(1'b0, (i == 0) ? first_pix : pix, 1'b0, 1'b0, 1'b1, edgeFor(kind, i));
    end
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 24'h0, 1'b0, (i == 2), 1'b0, 8'h00);
  endtask

  task automatic runVsync(output int v);
    v = cyc;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 24'h0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int s_a, s_b, s_d, s_e, s_f, s_g, h, v1, v2, v3, v4, r;
    for (int i = 0; i < LATENCY; i++) ehist[i] = '0;
    I_MODE      = 2'd0;
    I_THRESH    = 8'h00;
    I_OVL_COLOR = 24'h0;

    // Reset with garbage on every input.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 24'hABCDEF, 1'b1, 1'b1, 1'b1, 8'hFF);
    checkOutput("rst_pix", log_pix[cyc-1], 32'h0);
    checkOutput("rst_vs",  log_vs[cyc-1],  32'h0);
    checkOutput("rst_hs",  log_hs[cyc-1],  32'h0);
    checkOutput("rst_de",  log_de[cyc-1],  32'h0);
    checkOutput("rst_fc",  log_fc[cyc-1],  32'h0);
    checkOutput("rst_err", log_err[cyc-1], 32'h0);

    // Gray requested, but the first frame after reset stays in passthrough.
    I_MODE   = 2'd1;
    I_THRESH = 8'h80;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    runLine(640, 24'h123456, 24'h010203, 1, -1, 2'd0, 8'h00, s_a);
    checkOutput("lat_pre_de",  log_de[s_a+4],  32'h0);
    checkOutput("lat_pre_pix", log_pix[s_a+4], 32'h0);
    checkOutput("lat_de",      log_de[s_a+5],  32'h1);
    checkOutput("lat_pix",     log_pix[s_a+5], 32'h123456);
    checkOutput("first_pass",  log_pix[s_a+6], 32'h010203);
    checkOutput("de_last",     log_de[s_a+644], 32'h1);
    checkOutput("de_fall",     log_de[s_a+645], 32'h0);
    checkOutput("blank_pix",   log_pix[s_a+645], 32'h0);
    checkOutput("err_line_a",  log_err[s_a+645], 32'h0);
    h = s_a + 642;
    checkOutput("hs_pre",  log_hs[h+4], 32'h0);
    checkOutput("hs_at",   log_hs[h+5], 32'h1);
    checkOutput("hs_post", log_hs[h+6], 32'h0);

    runVsync(v1);
    checkOutput("vs_pre",   log_vs[v1+4], 32'h0);
    checkOutput("vs_rise",  log_vs[v1+5], 32'h1);
    checkOutput("vs_hold",  log_vs[v1+7], 32'h1);
    checkOutput("vs_fall",  log_vs[v1+8], 32'h0);
    checkOutput("fc_pre1",  log_fc[v1+4], 32'h0);
    checkOutput("fc_1",     log_fc[v1+5], 32'h1);

    // Frame 2: gray; I_MODE dropped to 0 mid-line must not matter.
    runLine(640, 24'h112233, 24'h112233, 1, 100, 2'd0, 8'h80, s_b);
    checkOutput("gray_p0",   log_pix[s_b+5],   32'h5A5A5A);
    checkOutput("gray_p7",   log_pix[s_b+12],  32'h070707);
    checkOutput("gray_p300", log_pix[s_b+305], 32'h2C2C2C);

    I_MODE      = 2'd2;
    I_THRESH    = 8'h80;
    I_OVL_COLOR = 24'hFF0000;
    runVsync(v2);
    checkOutput("fc_2", log_fc[v2+5], 32'h2);

    // Frame 3: overlay; threshold/mode changed mid-line must not matter.
    runLine(640, 24'h0A0B0C, 24'h0A0B0C, 2, 2, 2'd1, 8'h00, s_d);
    checkOutput("ovl_7f",   log_pix[s_d+5],  32'h0A0B0C);
    checkOutput("ovl_80",   log_pix[s_d+6],  32'hFF0000);
    checkOutput("ovl_ff",   log_pix[s_d+7],  32'hFF0000);
    checkOutput("ovl_00",   log_pix[s_d+8],  32'h0A0B0C);
    checkOutput("ovl_hold", log_pix[s_d+10], 32'h0A0B0C);
    checkOutput("err_line_d", log_err[s_d+645], 32'h0);

    runLine(639, 24'h0A0B0C, 24'h0A0B0C, 0, -1, 2'd0, 8'h00, s_e);
    checkOutput("short_pre_err", log_err[s_e+643], 32'h0);
    checkOutput("short_pre_de",  log_de[s_e+643],  32'h1);
    checkOutput("short_err",     log_err[s_e+644], 32'h1);
    checkOutput("short_de",      log_de[s_e+644],  32'h0);
    runLine(640, 24'h0A0B0C, 24'h0A0B0C, 0, -1, 2'd0, 8'h00, s_f);
    checkOutput("err_sticky", log_err[s_f+645], 32'h1);

    I_MODE = 2'd3;
    runVsync(v3);
    checkOutput("fc_pre3", log_fc[v3+4], 32'h2);
    checkOutput("fc_3",    log_fc[v3+5], 32'h3);

    runLine(640, 24'h445566, 24'h445566, 0, -1, 2'd3, 8'h00, s_g);
`ifdef EDGE_OUT_TP_EN
    checkOutput("tp_c0",   log_pix[s_g+5],   32'hFFFFFF);
    checkOutput("tp_c79",  log_pix[s_g+84],  32'hFFFFFF);
    checkOutput("tp_c80",  log_pix[s_g+85],  32'hFFFF00);
    checkOutput("tp_c240", log_pix[s_g+245], 32'h00FF00);
    checkOutput("tp_c560", log_pix[s_g+565], 32'h000000);
    checkOutput("tp_c639", log_pix[s_g+644], 32'h000000);
`else
    checkOutput("m3_c0",   log_pix[s_g+5],   32'h445566);
    checkOutput("m3_c639", log_pix[s_g+644], 32'h445566);
`endif

    // Frame counter wrap.
    force dut.frame_cnt_q = 16'hFFFF;
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    release dut.frame_cnt_q;
    checkOutput("fc_forced", 32'(O_FRAME_CNT), 32'hFFFF);
    runVsync(v4);
    checkOutput("fc_pre_wrap", log_fc[v4+4], 32'hFFFF);
    checkOutput("fc_wrap",     log_fc[v4+5], 32'h0);

    // Reset in the middle of an active line.
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 24'h5A5A5A, 1'b0, 1'b0, 1'b1, 8'h00);
    r = cyc;
    applyStimulus(1'b1, 24'h778899, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 24'h778899, 1'b0, 1'b0, 1'b1, 8'h00);
    checkOutput("mrst_pix",   log_pix[r], 32'h0);
    checkOutput("mrst_de",    log_de[r],  32'h0);
    checkOutput("mrst_fc",    log_fc[r],  32'h0);
    checkOutput("mrst_err",   log_err[r], 32'h0);
    checkOutput("mrst_drop2", log_de[r+2],  32'h0);
    checkOutput("mrst_drop3", log_pix[r+3], 32'h0);
    checkOutput("mrst_drop5", log_de[r+5],  32'h0);
    checkOutput("mrst_de6",   log_de[r+6],  32'h1);
    checkOutput("mrst_pass",  log_pix[r+6], 32'h778899);

    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
